// File: rtl/tpclk_if.sv
// Control and timing-output bundle for tpclk_gen; the generator attaches through
// the slave modport and whoever drives run/ilong/hang/sstep uses the master modport.
interface tpclk_if;
    // run is a level request, consumed only at a cycle boundary; there is no ready
    // return path, so busy and cyc_start are the only acknowledgement upstream sees.
    logic       run;
    logic       ilong;
    logic       hang;
    logic       sstep;
    logic       cyc_start;
    logic [4:0] tap_n;
    logic       tpclk;
    logic       tpwp;
    logic       busy;
    logic [1:0] state;

    modport master (
        output run, ilong, hang, sstep,
        input  cyc_start, tap_n, tpclk, tpwp, busy, state
    );

    modport slave (
        input  run, ilong, hang, sstep,
        output cyc_start, tap_n, tpclk, tpwp, busy, state
    );
endinterface

// File: rtl/tpclk_gen.sv
// Machine-cycle timing generator: cycle start, five tap strobes, TPCLK and TPWP from tick counting.
// Optional single-step request is built only when TPCLK_SSTEP_EN is defined.
module tpclk_gen #(
    parameter int TAP_TICKS   = 5,
    parameter int SHORT_TAPS  = 4,
    parameter int LONG_TAPS   = 5,
    parameter int PULSE_TICKS = 1
) (
    input  logic   clk,
    input  logic   reset_n,
    tpclk_if.slave bus
);

    localparam int TW = $clog2(LONG_TAPS * TAP_TICKS);
    localparam int PW = $clog2(TAP_TICKS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [TW-1:0] T_ZERO = '0;
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [PW-1:0] P_ZERO = '0;
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_LOAD = PW'(PULSE_TICKS - 1);

    logic [1:0]    r_state;
    logic [TW-1:0] r_t;
    logic          r_long;
    logic          r_cyc_start;
    logic [4:0]    r_tap_n;
    logic [PW-1:0] r_pcnt [5];
    logic          r_tpclk;
    logic          r_tpwp;
    logic          r_busy;

    logic          w_go;
    logic          w_last;
    logic [1:0]    w_nstate;
    logic [TW-1:0] w_nt;
    logic          w_start;
    logic          w_nlong;
    logic          w_nrun;
    int            w_cur_len;
    int            w_ntaps;
    int            w_nt_i;
    logic          w_tpclk_d;
    logic          w_tpwp_d;
    logic [4:0]    w_fire;

`ifdef TPCLK_SSTEP_EN
    // A single-step request behaves like run for exactly one boundary decision.
    assign w_go = bus.run | bus.sstep;
`else
    logic w_unused_sstep;
    assign w_unused_sstep = bus.sstep;
    assign w_go           = bus.run;
`endif

    assign w_cur_len = (r_long ? LONG_TAPS : SHORT_TAPS) * TAP_TICKS;
    assign w_last    = (r_state == S_RUN) && (int'(r_t) == w_cur_len - 1);

    always_comb begin
        w_nstate = r_state;
        w_nt     = r_t;
        w_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nt = T_ZERO;
                if (w_go) begin
                    w_nstate = S_RUN;
                    w_start  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_nt = T_ZERO;
                    if (bus.hang) begin
                        w_nstate = S_HOLD;
                    end else if (bus.run) begin
                        w_nstate = S_RUN;
                        w_start  = 1'b1;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end else begin
                    w_nt = r_t + T_ONE;
                end
            end
            S_HOLD: begin
                w_nt = T_ZERO;
                if (!bus.hang) begin
                    if (bus.run) begin
                        w_nstate = S_RUN;
                        w_start  = 1'b1;
                    end else begin
                        w_nstate = S_IDLE;
                    end
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_nt     = T_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next tick's values so every output is a flop.
    always_comb begin
        w_nlong   = w_start ? bus.ilong : r_long;
        w_ntaps   = w_nlong ? LONG_TAPS : SHORT_TAPS;
        w_nrun    = (w_nstate == S_RUN);
        w_nt_i    = int'(w_nt);
        w_tpclk_d = w_nrun && (w_nt_i < 2 * TAP_TICKS);
        w_tpwp_d  = w_nrun && (w_nt_i >= (w_ntaps - 2) * TAP_TICKS)
                           && (w_nt_i <  (w_ntaps - 1) * TAP_TICKS);
        w_fire    = '0;
        for (int k = 0; k < 5; k++) begin
            w_fire[k] = w_nrun && (k < w_ntaps) && (w_nt_i == (k + 1) * TAP_TICKS - 1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_t         <= T_ZERO;
            r_long      <= 1'b0;
            r_cyc_start <= 1'b0;
            r_tpclk     <= 1'b0;
            r_tpwp      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_t         <= w_nt;
            r_long      <= w_nlong;
            r_cyc_start <= w_start;
            r_tpclk     <= w_tpclk_d;
            r_tpwp      <= w_tpwp_d;
            r_busy      <= (w_nstate != S_IDLE);
        end
    end

    // Each strobe times its own width, so the last tap can spill into the next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tap_n <= 5'h1F;
            for (int k = 0; k < 5; k++) begin
                r_pcnt[k] <= P_ZERO;
            end
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (w_fire[k]) begin
                    r_tap_n[k] <= 1'b0;
                    r_pcnt[k]  <= P_LOAD;
                end else if (r_pcnt[k] != P_ZERO) begin
                    r_pcnt[k]  <= r_pcnt[k] - P_ONE;
                end else begin
                    r_tap_n[k] <= 1'b1;
                end
            end
        end
    end

    assign bus.cyc_start = r_cyc_start;
    assign bus.tap_n     = r_tap_n;
    assign bus.tpclk     = r_tpclk;
    assign bus.tpwp      = r_tpwp;
    assign bus.busy      = r_busy;
    assign bus.state     = r_state;

endmodule
